// File: rtl/match_sequencer.sv
// Match-level control for a two-player paddle game: idle, timed serve, rally play
// and match end, with registered score, winner and ball-control outputs.
module match_sequencer #(
  parameter int unsigned WIN_SCORE   = 10,
  parameter int unsigned SERVE_DELAY = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       point_left,
  input  logic       point_right,
  output logic [1:0] state,
  output logic [3:0] left_score,
  output logic [3:0] right_score,
  output logic       ball_en,
  output logic       ball_recenter,
  output logic       serve_dir,
  output logic [1:0] winner
);

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_SERVE = 2'b01;
  localparam logic [1:0] S_PLAY  = 2'b10;
  localparam logic [1:0] S_DONE  = 2'b11;

  localparam logic [3:0] WIN        = 4'(WIN_SCORE);
  localparam logic [7:0] DELAY_LOAD = 8'(SERVE_DELAY - 1);

  localparam logic [1:0] WIN_NONE  = 2'b00;
  localparam logic [1:0] WIN_LEFT  = 2'b01;
  localparam logic [1:0] WIN_RIGHT = 2'b10;

  logic [1:0] state_q, state_d;
  logic [3:0] left_q, left_d;
  logic [3:0] right_q, right_d;
  logic       ball_en_q, ball_en_d;
  logic       recenter_q, recenter_d;
  logic       dir_q, dir_d;
  logic [1:0] winner_q, winner_d;
  logic [7:0] cnt_q, cnt_d;
  logic       start_q;
  logic       armed_q;

  logic       start_rise;
  logic [3:0] left_inc;
  logic [3:0] right_inc;

  // armed_q masks the first edge after reset so a start level already high
  // at release is captured into start_q without being seen as a rising edge.
  assign start_rise = start & ~start_q & armed_q;
  assign left_inc   = left_q + 4'd1;
  assign right_inc  = right_q + 4'd1;

  always_comb begin
    state_d    = state_q;
    left_d     = left_q;
    right_d    = right_q;
    dir_d      = dir_q;
    winner_d   = winner_q;
    cnt_d      = cnt_q;
    recenter_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_rise) begin
          state_d    = S_SERVE;
          left_d     = 4'd0;
          right_d    = 4'd0;
          winner_d   = WIN_NONE;
          dir_d      = 1'b0;
          cnt_d      = DELAY_LOAD;
          recenter_d = 1'b1;
        end
      end
      S_SERVE: begin
        if (cnt_q == 8'd0) begin
          state_d = S_PLAY;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_PLAY: begin
        if (point_left && point_right) begin
          state_d    = S_SERVE;
          cnt_d      = DELAY_LOAD;
          recenter_d = 1'b1;
        end else if (point_left) begin
          left_d = left_inc;
          if (left_inc == WIN) begin
            state_d  = S_DONE;
            winner_d = WIN_LEFT;
          end else begin
            state_d    = S_SERVE;
            dir_d      = 1'b0;
            cnt_d      = DELAY_LOAD;
            recenter_d = 1'b1;
          end
        end else if (point_right) begin
          right_d = right_inc;
          if (right_inc == WIN) begin
            state_d  = S_DONE;
            winner_d = WIN_RIGHT;
          end else begin
            state_d    = S_SERVE;
            dir_d      = 1'b1;
            cnt_d      = DELAY_LOAD;
            recenter_d = 1'b1;
          end
        end
      end
      default: begin
      end
    endcase

    // Dropping start outside IDLE aborts the match and beats any point pulse.
    if ((state_q != S_IDLE) && !start) begin
      state_d    = S_IDLE;
      left_d     = 4'd0;
      right_d    = 4'd0;
      winner_d   = WIN_NONE;
      dir_d      = 1'b0;
      cnt_d      = 8'd0;
      recenter_d = 1'b0;
    end

    ball_en_d = (state_d == S_PLAY);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      left_q     <= 4'd0;
      right_q    <= 4'd0;
      ball_en_q  <= 1'b0;
      recenter_q <= 1'b0;
      dir_q      <= 1'b0;
      winner_q   <= WIN_NONE;
      cnt_q      <= 8'd0;
      start_q    <= 1'b0;
      armed_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      left_q     <= left_d;
      right_q    <= right_d;
      ball_en_q  <= ball_en_d;
      recenter_q <= recenter_d;
      dir_q      <= dir_d;
      winner_q   <= winner_d;
      cnt_q      <= cnt_d;
      start_q    <= start;
      armed_q    <= 1'b1;
    end
  end

  assign state         = state_q;
  assign left_score    = left_q;
  assign right_score   = right_q;
  assign ball_en       = ball_en_q;
  assign ball_recenter = recenter_q;
  assign serve_dir     = dir_q;
  assign winner        = winner_q;

endmodule
